fetch_unit: RTL

//  Instruction-fetch stage of the 5-stage pipeline. Owns the PC and drives the icache request.

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 70 +++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: icache, hazard-unit and F/D-latch signals of the fetch stage
interface fetch_unit_if #(parameter int CNT_W = 32);
    logic             ihit;
    logic [31:0]      iload;
    logic             fden;
    logic             halt;
    logic             branching;
    logic [31:0]      branch_target;
    logic             jumping;
    logic [31:0]      jump_target;
    logic             iren;
    logic [31:0]      iaddr;
    logic [31:0]      instr;
    logic [31:0]      npc;
    logic             fetch_valid;
    logic [CNT_W-1:0] fetch_count;
    modport master (
        output ihit, iload, fden, halt, branching, branch_target, jumping, jump_target,
        input  iren, iaddr, instr, npc, fetch_valid, fetch_count
    );
    modport slave (
        input  ihit, iload, fden, halt, branching, branch_target, jumping, jump_target,
        output iren, iaddr, instr, npc, fetch_valid, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and icache requester; defers redirects across misses, freezes on halt
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          CNT_W   = 32
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.slave  bus_io
);
    typedef enum logic [1:0] {RUN, REDIR_WAIT, HALTED} state_e;
    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d, pend_q, pend_d, tgt;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               redir;
    assign redir = bus_io.branching | bus_io.jumping;
    assign tgt   = bus_io.branching ? bus_io.branch_target : bus_io.jump_target;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (bus_io.halt) state_d = HALTED;
                else if (redir && bus_io.ihit) pc_d = tgt;
                else if (redir) begin
                    pend_d  = tgt;
                    state_d = REDIR_WAIT;
                end else if (bus_io.ihit && bus_io.fden) begin
                    pc_d  = pc_q + 32'd4;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REDIR_WAIT: begin
                // the miss in flight completes at the old PC; its word is dropped
                if (bus_io.halt) state_d = HALTED;
                else if (redir) begin
                    pend_d = tgt;
                    if (bus_io.ihit) begin
                        pc_d    = tgt;
                        state_d = RUN;
                    end
                end else if (bus_io.ihit) begin
                    pc_d    = pend_q;
                    state_d = RUN;
                end
            end
            default: state_d = HALTED;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= PC_INIT;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus_io.iren        = state_q != HALTED;
    assign bus_io.iaddr       = pc_q;
    assign bus_io.npc         = pc_q + 32'd4;
    assign bus_io.instr       = bus_io.iload;
    assign bus_io.fetch_valid = bus_io.ihit & (state_q == RUN) & ~redir & ~bus_io.halt;
    assign bus_io.fetch_count = cnt_q;
endmodule
